// File: rtl/divider_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
// Optional feature macro used by the top level: DIVIDER_FAST_PATH_EN.
package divider_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int PR_W       = DIVISOR_W + 1;
   localparam int STEP_W     = 5;

   localparam logic [STEP_W-1:0]     STEP_LAST    = 5'd15;
   localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step
   import divider_pkg::*;
(
   input  logic [PR_W-1:0]      pr,
   input  logic                 n_bit,
   input  logic [DIVISOR_W-1:0] d,
   output logic [PR_W-1:0]      pr_next,
   output logic                 q_bit
);

   logic [PR_W-1:0] shifted;
   logic [PR_W-1:0] diff;

   // PR is one bit wider than D, so the compare and subtract never wrap.
   assign shifted = {pr[DIVISOR_W-1:0], n_bit};
   assign diff    = shifted - {1'b0, d};
   assign q_bit   = (shifted >= {1'b0, d});
   assign pr_next = q_bit ? diff : shifted;

endmodule

// File: rtl/restoring_divider_16by8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock.
// Define DIVIDER_FAST_PATH_EN to skip CALC when D == 0 or N < D.
module restoring_divider_16by8
   import divider_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output state_t                fsm_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.

   state_t                state;
   state_t                state_next;
   logic [STEP_W-1:0]     step;
   logic [DIVIDEND_W-1:0] n_q;
   logic [DIVISOR_W-1:0]  d_q;
   logic [PR_W-1:0]       pr;
   logic                  accept;
   logic                  last_step;
   logic                  fast_hit;

   logic [PR_W-1:0]       pr_next;
   logic                  q_bit;

   div_step u_div_step (
      .pr      (pr),
      .n_bit   (n_q[DIVIDEND_W-1]),
      .d       (d_q),
      .pr_next (pr_next),
      .q_bit   (q_bit)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign fsm_state = state;
   assign accept    = in_valid && in_ready;
   assign last_step = (step == STEP_LAST);

`ifdef DIVIDER_FAST_PATH_EN
   assign fast_hit = (divisor == '0) || (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor});
`else
   assign fast_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = fast_hit ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // n_q shifts dividend bits out of the top and quotient bits in at the
   // bottom, so after 16 steps it holds the quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step        <= '0;
         n_q         <= '0;
         d_q         <= '0;
         pr          <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  n_q  <= dividend;
                  d_q  <= divisor;
                  pr   <= '0;
                  step <= '0;
                  if (fast_hit) begin
                     quotient    <= (divisor == '0) ? DBZ_QUOTIENT : '0;
                     remainder   <= dividend[DIVISOR_W-1:0];
                     div_by_zero <= (divisor == '0);
                  end
               end
            end
            CALC: begin
               n_q  <= {n_q[DIVIDEND_W-2:0], q_bit};
               pr   <= pr_next;
               step <= step + 5'd1;
               if (last_step) begin
                  // With D == 0 every step subtracts nothing, so PR ends as N[7:0].
                  quotient    <= (d_q == '0) ? DBZ_QUOTIENT : {n_q[DIVIDEND_W-2:0], q_bit};
                  remainder   <= pr_next[DIVISOR_W-1:0];
                  div_by_zero <= (d_q == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider_16by8.sv
// Self-checking bench for restoring_divider_16by8: directed cases, backpressure,
// mid-operation reset and random operands against a software N/D model.
module tb_restoring_divider_16by8;
   import divider_pkg::*;

   localparam int RES_W = 25;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   state_t      fsm_state;

   logic [RES_W-1:0] exp_q[$];
   int               asserts;
   int               fails;
   int               overlap_cnt;

   restoring_divider_16by8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && in_ready && out_valid) overlap_cnt++;
   end

   function automatic logic [RES_W-1:0] model(input logic [15:0] n, input logic [7:0] d);
      logic [15:0] q;
      logic [7:0]  r;
      if (d == 8'd0) return {16'hFFFF, n[7:0], 1'b1};
      q = n / {8'd0, d};
      r = 8'(n % {8'd0, d});
      return {q, r, 1'b0};
   endfunction

   function automatic int exp_latency(input logic [15:0] n, input logic [7:0] d);
`ifdef DIVIDER_FAST_PATH_EN
      if (d == 8'd0 || n < {8'd0, d}) return 0;
`endif
      return 16;
   endfunction

   // driver: present operands, complete the input handshake, push expectation
   task automatic start_op(input logic [15:0] n, input logic [7:0] d);
      int waited;
      @(negedge clk);
      in_valid = 1'b1;
      dividend = n;
      divisor  = d;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      asserts++;
      if (!in_ready) begin
         fails++;
         $display("FAIL start_timeout in_ready=%0b required=1", in_ready);
      end
      @(posedge clk);
      exp_q.push_back(model(n, d));
      #1;
      in_valid = 1'b0;
   endtask

   // counts rising edges after the handshake edge until out_valid is seen
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      asserts++;
      if (!out_valid) begin
         fails++;
         $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
      end
   endtask

   // scoreboard: pop the expectation, compare, then take the result
   task automatic consume(input string tag);
      logic [RES_W-1:0] exp;
      asserts++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s_queue_empty size=0 required>0", tag);
         exp = '0;
      end else begin
         exp = exp_q.pop_front();
      end
      asserts++;
      if ({quotient, remainder, div_by_zero} !== exp) begin
         fails++;
         $display("FAIL %s_result q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                  tag, quotient, remainder, div_by_zero, exp[24:9], exp[8:1], exp[0]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      asserts++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_release out_valid=%0b in_ready=%0b required 0/1", tag, out_valid, in_ready);
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] n, input logic [7:0] d);
      int lat;
      start_op(n, d);
      wait_result(lat);
      asserts++;
      if (lat != exp_latency(n, d)) begin
         fails++;
         $display("FAIL %s_latency got=%0d required=%0d", tag, lat, exp_latency(n, d));
      end
      consume(tag);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
          remainder !== 8'd0 || div_by_zero !== 1'b0 || fsm_state !== IDLE) begin
         fails++;
         $display("FAIL reset_state rdy=%0b vld=%0b q=%0d r=%0d dbz=%0b st=%0d required 1/0/0/0/0/IDLE",
                  in_ready, out_valid, quotient, remainder, div_by_zero, fsm_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op("n1000_d7", 16'd1000, 8'd7);
      run_op("nmax_d255", 16'd65535, 8'd255);
      run_op("nmax_d1", 16'd65535, 8'd1);
      run_op("div_zero", 16'd5, 8'd0);
      run_op("n_lt_d", 16'd3, 8'd200);
      run_op("n_eq_d", 16'd200, 8'd200);
      run_op("n0_d0", 16'd0, 8'd0);
   endtask

   task automatic test_backpressure();
      logic [RES_W-1:0] exp;
      int lat;
      start_op(16'd50000, 8'd13);
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 16'd1;
         divisor  = 8'd1;
         asserts++;
         if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_busy_ready in_ready=%0b required=0", in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      wait_result(lat);
      exp = model(16'd50000, 8'd13);
      repeat (5) begin
         @(posedge clk);
         #1;
         asserts++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {quotient, remainder, div_by_zero} !== exp) begin
            fails++;
            $display("FAIL bp_hold vld=%0b rdy=%0b q=%0d r=%0d required 1/0 q=%0d r=%0d",
                     out_valid, in_ready, quotient, remainder, exp[24:9], exp[8:1]);
         end
      end
      consume("backpressure");
      asserts++;
      if (fsm_state !== IDLE) begin
         fails++;
         $display("FAIL bp_no_extra_op state=%0d required=IDLE", fsm_state);
      end
   endtask

   task automatic test_reset_mid_op();
      start_op(16'd1000, 8'd7);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      asserts++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || fsm_state !== IDLE) begin
         fails++;
         $display("FAIL midreset_state rdy=%0b vld=%0b st=%0d required 1/0/IDLE",
                  in_ready, out_valid, fsm_state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset", 16'd1000, 8'd7);
   endtask

   task automatic test_random(input int count);
      logic [15:0] n;
      logic [7:0]  d;
      for (int i = 0; i < count; i++) begin
         n = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) n = 16'($urandom_range(0, 300));
         d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_op("random", n, d);
      end
   endtask

   initial begin
      asserts     = 0;
      fails       = 0;
      overlap_cnt = 0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_op();
      test_random(2000);
      asserts++;
      if (overlap_cnt != 0) begin
         fails++;
         $display("FAIL ready_valid_overlap count=%0d required=0", overlap_cnt);
      end
      asserts++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_leftover size=%0d required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
